// File: rtl/load_spill_align.sv
// load_spill_align
//
// Fetches the one or two memory words that a load touches and assembles
// them into one aligned word for the subword extract / sign-extend stage.
// A load whose bytes cross the LLEN boundary ("spill") takes two beats:
// the word containing PAdrM, then the next sequential word. The two words
// are funnel-shifted so that the addressed byte lands at byte 0. The
// downstream offset is then 0.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   LoadReqM          load request, held until LoadValidM
//   PAdrM, Funct3M    low address bits and funct3 of the load
//   FlushM            abort of the in-flight load
//   MemRdReq          beat request to memory
//   MemWordSel        0 = word containing PAdr, 1 = next word
//   MemRdValid        beat return strobe
//   MemRdData         beat return data
//   ReadDataWordMuxM  assembled word (held until the next completion)
//   PAdrOutM          byte offset for the extract stage
//   Funct3OutM        captured funct3
//   LoadValidM        one-cycle completion strobe
//   StallM            pipeline stall while a load is in flight
//   MisalignedM       the current load spans two words
module load_spill_align #(
    parameter int LLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            LoadReqM,
    input  logic [2:0]      PAdrM,
    input  logic [2:0]      Funct3M,
    input  logic            FlushM,
    output logic            MemRdReq,
    output logic            MemWordSel,
    input  logic            MemRdValid,
    input  logic [LLEN-1:0] MemRdData,
    output logic [LLEN-1:0] ReadDataWordMuxM,
    output logic [2:0]      PAdrOutM,
    output logic [2:0]      Funct3OutM,
    output logic            LoadValidM,
    output logic            StallM,
    output logic            MisalignedM
);

    localparam int OB    = (LLEN == 64) ? 3 : 2;
    localparam int BYTES = LLEN / 8;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t          state;
    logic [2:0]      padr_q;
    logic [2:0]      funct3_q;
    logic [LLEN-1:0] w0;

    logic [3:0]      size_now;
    logic [4:0]      off_now;
    logic            spill_now;
    logic [OB+2:0]   shamt;
    logic [LLEN-1:0] spill_word;

    // Spill test on the live request; it is captured on acceptance.
    assign size_now  = 4'd1 << Funct3M[1:0];
    assign off_now   = 5'(PAdrM[OB-1:0]);
    assign spill_now = (off_now + 5'(size_now)) > 5'(BYTES);

    // Second beat is funneled straight into the output register together
    // with the stored first beat, so no separate W1 holding register is needed.
    assign shamt      = {padr_q[OB-1:0], 3'b000};
    assign spill_word = LLEN'({MemRdData, w0} >> shamt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            padr_q           <= '0;
            funct3_q         <= '0;
            w0               <= '0;
            ReadDataWordMuxM <= '0;
            PAdrOutM         <= '0;
            Funct3OutM       <= '0;
            MisalignedM      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LoadReqM && !FlushM) begin
                        padr_q      <= PAdrM;
                        funct3_q    <= Funct3M;
                        MisalignedM <= spill_now;
                        state       <= BEAT0;
                    end
                end
                BEAT0: begin
                    // Flush wins over a same-cycle beat return.
                    if (FlushM) begin
                        state <= IDLE;
                    end else if (MemRdValid) begin
                        w0 <= MemRdData;
                        if (MisalignedM) begin
                            state <= BEAT1;
                        end else begin
                            ReadDataWordMuxM <= MemRdData;
                            PAdrOutM         <= padr_q;
                            Funct3OutM       <= funct3_q;
                            state            <= DONE;
                        end
                    end
                end
                BEAT1: begin
                    if (FlushM) begin
                        state <= IDLE;
                    end else if (MemRdValid) begin
                        ReadDataWordMuxM <= spill_word;
                        PAdrOutM         <= 3'd0;
                        Funct3OutM       <= funct3_q;
                        state            <= DONE;
                    end
                end
                default: begin
                    // DONE: never accepts a new request (one bubble).
                    state <= IDLE;
                end
            endcase
        end
    end

    assign MemRdReq   = (state == BEAT0) || (state == BEAT1);
    assign MemWordSel = (state == BEAT1);
    assign LoadValidM = (state == DONE) && !FlushM;
    // Gated by reset so the stall drops together with the async reset even
    // if the requester is still holding LoadReqM.
    assign StallM     = !reset && (((state == IDLE) && LoadReqM) || MemRdReq);

endmodule

// File: tb/tb_load_spill_align.sv
// Directed testbench for load_spill_align (LLEN = 64).
module tb_load_spill_align;

    logic        clk;
    logic        reset;
    logic        LoadReqM;
    logic [2:0]  PAdrM;
    logic [2:0]  Funct3M;
    logic        FlushM;
    logic        MemRdReq;
    logic        MemWordSel;
    logic        MemRdValid;
    logic [63:0] MemRdData;
    logic [63:0] ReadDataWordMuxM;
    logic [2:0]  PAdrOutM;
    logic [2:0]  Funct3OutM;
    logic        LoadValidM;
    logic        StallM;
    logic        MisalignedM;

    int vectors;
    int miscompares;

    load_spill_align #(.LLEN(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .LoadReqM         (LoadReqM),
        .PAdrM            (PAdrM),
        .Funct3M          (Funct3M),
        .FlushM           (FlushM),
        .MemRdReq         (MemRdReq),
        .MemWordSel       (MemWordSel),
        .MemRdValid       (MemRdValid),
        .MemRdData        (MemRdData),
        .ReadDataWordMuxM (ReadDataWordMuxM),
        .PAdrOutM         (PAdrOutM),
        .Funct3OutM       (Funct3OutM),
        .LoadValidM       (LoadValidM),
        .StallM           (StallM),
        .MisalignedM      (MisalignedM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        LoadReqM    = 1'b0;
        PAdrM       = 3'd0;
        Funct3M     = 3'd0;
        FlushM      = 1'b0;
        MemRdValid  = 1'b0;
        MemRdData   = 64'd0;
        tick();
        #1;
        chk("rst_rdata",  ReadDataWordMuxM, 64'd0);
        chk("rst_padr",   PAdrOutM, 64'd0);
        chk("rst_f3",     Funct3OutM, 64'd0);
        chk("rst_misal",  MisalignedM, 64'd0);
        chk("rst_memreq", MemRdReq, 64'd0);
        chk("rst_valid",  LoadValidM, 64'd0);
        chk("rst_stall",  StallM, 64'd0);
        tick();
        reset = 1'b0;

        // lw at offset 4, immediate beat: done 2 cycles after acceptance
        tick();
        LoadReqM = 1'b1; PAdrM = 3'd4; Funct3M = 3'b010;
        #1;
        chk("lw_idle_stall", StallM, 64'd1);
        tick();
        MemRdValid = 1'b1; MemRdData = 64'h1122334455667788;
        #1;
        chk("lw_b0_req", MemRdReq, 64'd1);
        chk("lw_b0_sel", MemWordSel, 64'd0);
        chk("lw_b0_valid", LoadValidM, 64'd0);
        tick();
        MemRdValid = 1'b0; LoadReqM = 1'b0;
        #1;
        chk("lw_valid", LoadValidM, 64'd1);
        chk("lw_stall", StallM, 64'd0);
        chk("lw_rdata", ReadDataWordMuxM, 64'h1122334455667788);
        chk("lw_padr",  PAdrOutM, 64'd4);
        chk("lw_f3",    Funct3OutM, 64'd2);
        chk("lw_misal", MisalignedM, 64'd0);
        tick();
        chk("lw_valid_once", LoadValidM, 64'd0);

        // ld at offset 5: spill, two beats, done 3 cycles after acceptance
        LoadReqM = 1'b1; PAdrM = 3'd5; Funct3M = 3'b011;
        tick();
        MemRdValid = 1'b1; MemRdData = 64'h8877665544332211;
        #1;
        chk("ld_b0_sel", MemWordSel, 64'd0);
        chk("ld_b0_req", MemRdReq, 64'd1);
        tick();
        MemRdData = 64'h00FFEEDDCCBBAA99;
        #1;
        chk("ld_b1_sel", MemWordSel, 64'd1);
        chk("ld_b1_req", MemRdReq, 64'd1);
        chk("ld_b1_valid", LoadValidM, 64'd0);
        tick();
        MemRdValid = 1'b0; LoadReqM = 1'b0;
        #1;
        chk("ld_valid", LoadValidM, 64'd1);
        chk("ld_rdata", ReadDataWordMuxM, 64'hDDCCBBAA99887766);
        chk("ld_padr",  PAdrOutM, 64'd0);
        chk("ld_misal", MisalignedM, 64'd1);
        tick();

        // lh at offset 7 spills by one byte
        LoadReqM = 1'b1; PAdrM = 3'd7; Funct3M = 3'b001;
        tick();
        MemRdValid = 1'b1; MemRdData = 64'h8877665544332211;
        tick();
        MemRdData = 64'h00FFEEDDCCBBAA99;
        tick();
        MemRdValid = 1'b0; LoadReqM = 1'b0;
        #1;
        chk("lh_valid", LoadValidM, 64'd1);
        chk("lh_half",  {48'd0, ReadDataWordMuxM[15:0]}, 64'h9988);
        chk("lh_rdata", ReadDataWordMuxM, 64'hFFEEDDCCBBAA9988);
        chk("lh_padr",  PAdrOutM, 64'd0);
        chk("lh_f3",    Funct3OutM, 64'd1);
        tick();

        // lw at offset 6 spills; each beat returns after 3 idle cycles
        LoadReqM = 1'b1; PAdrM = 3'd6; Funct3M = 3'b010;
        for (int c = 1; c <= 8; c++) begin
            tick();
            MemRdValid = (c == 4) || (c == 8);
            MemRdData  = (c <= 4) ? 64'h0706050403020100 : 64'h0F0E0D0C0B0A0908;
            #1;
            chk($sformatf("slow_stall_c%0d", c), StallM, 64'd1);
            chk($sformatf("slow_valid_c%0d", c), LoadValidM, 64'd0);
            chk($sformatf("slow_sel_c%0d", c), MemWordSel, (c >= 5) ? 64'd1 : 64'd0);
            chk($sformatf("slow_hold_c%0d", c), ReadDataWordMuxM, 64'hFFEEDDCCBBAA9988);
        end
        tick();
        MemRdValid = 1'b0; LoadReqM = 1'b0;
        #1;
        chk("slow_valid_c9", LoadValidM, 64'd1);
        chk("slow_rdata", ReadDataWordMuxM, 64'h0D0C0B0A09080706);
        tick();
        chk("slow_valid_c10", LoadValidM, 64'd0);

        // Flush in BEAT1 coincident with the beat return
        LoadReqM = 1'b1; PAdrM = 3'd5; Funct3M = 3'b011;
        tick();
        MemRdValid = 1'b1; MemRdData = 64'h8877665544332211;
        tick();
        MemRdData = 64'h00FFEEDDCCBBAA99; FlushM = 1'b1; LoadReqM = 1'b0;
        #1;
        chk("fl_b1_valid", LoadValidM, 64'd0);
        tick();
        MemRdValid = 1'b0; FlushM = 1'b0;
        #1;
        chk("fl_idle_req",   MemRdReq, 64'd0);
        chk("fl_idle_stall", StallM, 64'd0);
        chk("fl_idle_valid", LoadValidM, 64'd0);
        chk("fl_retained",   ReadDataWordMuxM, 64'h0D0C0B0A09080706);
        // following lw completes normally
        LoadReqM = 1'b1; PAdrM = 3'd0; Funct3M = 3'b010;
        tick();
        MemRdValid = 1'b1; MemRdData = 64'hA5A5A5A55A5A5A5A;
        tick();
        MemRdValid = 1'b0; LoadReqM = 1'b0;
        #1;
        chk("after_fl_valid", LoadValidM, 64'd1);
        chk("after_fl_rdata", ReadDataWordMuxM, 64'hA5A5A5A55A5A5A5A);
        chk("after_fl_padr",  PAdrOutM, 64'd0);
        tick();

        // Flush in DONE suppresses the strobe, FSM still returns to IDLE
        LoadReqM = 1'b1; PAdrM = 3'd0; Funct3M = 3'b011;
        tick();
        MemRdValid = 1'b1; MemRdData = 64'h0123456789ABCDEF;
        tick();
        MemRdValid = 1'b0; LoadReqM = 1'b0; FlushM = 1'b1;
        #1;
        chk("fdone_valid", LoadValidM, 64'd0);
        tick();
        FlushM = 1'b0;
        #1;
        chk("fdone_idle_req",   MemRdReq, 64'd0);
        chk("fdone_idle_valid", LoadValidM, 64'd0);

        // Reset pulse in BEAT0 of a spilling ld, then a stale beat
        LoadReqM = 1'b1; PAdrM = 3'd3; Funct3M = 3'b011;
        tick();
        #1;
        chk("rb_b0_req",   MemRdReq, 64'd1);
        chk("rb_b0_misal", MisalignedM, 64'd1);
        reset = 1'b1;
        #1;
        chk("rb_req",   MemRdReq, 64'd0);
        chk("rb_stall", StallM, 64'd0);
        chk("rb_valid", LoadValidM, 64'd0);
        chk("rb_rdata", ReadDataWordMuxM, 64'd0);
        chk("rb_padr",  PAdrOutM, 64'd0);
        chk("rb_f3",    Funct3OutM, 64'd0);
        chk("rb_misal", MisalignedM, 64'd0);
        #1;
        reset = 1'b0; LoadReqM = 1'b0;
        tick();
        MemRdValid = 1'b1; MemRdData = 64'hDEADBEEFDEADBEEF;
        #1;
        chk("stale_req",   MemRdReq, 64'd0);
        chk("stale_stall", StallM, 64'd0);
        tick();
        MemRdValid = 1'b0;
        #1;
        chk("stale_valid", LoadValidM, 64'd0);
        chk("stale_rdata", ReadDataWordMuxM, 64'd0);
        chk("stale_req2",  MemRdReq, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
